// File: rtl/float_division.sv
// float_division
// Sequential IEEE-754 single-precision divider (Quotient = Number_1 / Number_2).
// A restoring mantissa divider produces one quotient bit per enabled cycle;
// the mantissa is truncated, denormals are flushed to zero, and an input
// exponent of 255 is treated as an ordinary number.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset (priority over ce)
//   ce        clock enable; when low all state and outputs hold
//   Start     request, accepted only while idle
//   Number_1  dividend, latched on an accepted Start
//   Number_2  divisor, latched on an accepted Start
//   Quotient  result register, held until the next result
//   Valid     one-enabled-cycle pulse when Quotient is updated
//   Busy      high from the accepting edge until the result edge
module float_division (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        Start,
  input  logic [31:0] Number_1,
  input  logic [31:0] Number_2,
  output logic [31:0] Quotient,
  output logic        Valid,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM
  } state_t;

  state_t      state, state_nxt;

  logic        sign_r;
  logic [7:0]  e1_r, e2_r;
  logic [25:0] rem_r;
  logic [23:0] div_r;
  logic [24:0] q_r;
  logic [4:0]  cnt_r;

  logic        rem_ge;
  logic [25:0] rem_next;
  logic [9:0]  exp_u;
  logic [22:0] mant;
  logic [31:0] result;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = DIVIDE;
      DIVIDE:  if (cnt_r == 5'd24) state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  // One restoring-division step. rem stays below 2*div, so the shifted
  // remainder never exceeds 26 bits.
  always_comb begin
    rem_ge   = (rem_r >= {2'b00, div_r});
    rem_next = rem_r << 1;
    if (rem_ge) rem_next = (rem_r - {2'b00, div_r}) << 1;
  end

  // Exponent is computed modulo 2^10 and then read as two's complement:
  // bit 9 set means negative, so "E <= 0" and "E >= 255" are plain bit tests.
  always_comb begin
    exp_u  = {2'b00, e1_r} - {2'b00, e2_r} + 10'd127 - {9'd0, ~q_r[24]};
    mant   = q_r[24] ? q_r[23:1] : q_r[22:0];
    result = {sign_r, exp_u[7:0], mant};
    if (e1_r == 8'd0 && e2_r == 8'd0)
      result = 32'h7FC0_0000;
    else if (e2_r == 8'd0)
      result = {sign_r, 8'hFF, 23'd0};
    else if (e1_r == 8'd0)
      result = {sign_r, 31'd0};
    else if (!exp_u[9] && exp_u >= 10'd255)
      result = {sign_r, 8'hFF, 23'd0};
    else if (exp_u[9] || exp_u == 10'd0)
      result = {sign_r, 31'd0};
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r   <= 1'b0;
      e1_r     <= '0;
      e2_r     <= '0;
      rem_r    <= '0;
      div_r    <= '0;
      q_r      <= '0;
      cnt_r    <= '0;
      Quotient <= '0;
      Valid    <= 1'b0;
      Busy     <= 1'b0;
    end else if (ce) begin
      Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            sign_r <= Number_1[31] ^ Number_2[31];
            e1_r   <= Number_1[30:23];
            e2_r   <= Number_2[30:23];
            rem_r  <= {2'b01, Number_1[22:0]};
            div_r  <= {1'b1, Number_2[22:0]};
            q_r    <= '0;
            cnt_r  <= '0;
            Busy   <= 1'b1;
          end
        end
        DIVIDE: begin
          q_r   <= {q_r[23:0], rem_ge};
          rem_r <= rem_next;
          cnt_r <= cnt_r + 5'd1;
        end
        NORM: begin
          Quotient <= result;
          Valid    <= 1'b1;
          Busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_division.sv
module tb_float_division;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        Start;
  logic [31:0] Number_1;
  logic [31:0] Number_2;
  logic [31:0] Quotient;
  logic        Valid;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  float_division dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .Start    (Start),
    .Number_1 (Number_1),
    .Number_2 (Number_2),
    .Quotient (Quotient),
    .Valid    (Valid),
    .Busy     (Busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference quotient from plain integer arithmetic on the operands.
  function automatic logic [31:0] exp_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, mq;
    int e1, e2, e;
    logic s;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    if (e1 == 0 && e2 == 0) return 32'h7FC0_0000;
    if (e2 == 0) return {s, 8'hFF, 23'd0};
    if (e1 == 0) return {s, 31'd0};
    ma = 64'd8388608 + longint'(a[22:0]);
    mb = 64'd8388608 + longint'(b[22:0]);
    mq = (ma << 24) / mb;                  // floor(2^24 * ma / mb)
    if (mq >= 64'd16777216) begin
      e = e1 - e2 + 127;
      m = mq[23:1];
    end else begin
      e = e1 - e2 + 126;
      m = mq[22:0];
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], m};
  endfunction

  // Cycle model: 26 enabled edges from acceptance to result.
  logic        m_init = 1'b0;
  logic        m_busy = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_q = '0;
  logic [31:0] m_pend = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1'b1;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_q     <= '0;
      m_left  <= 0;
    end else if (ce) begin
      m_valid <= 1'b0;
      if (!m_busy) begin
        if (Start) begin
          m_busy <= 1'b1;
          m_left <= 26;
          m_pend <= exp_div(Number_1, Number_2);
        end
      end else begin
        if (m_left == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_q     <= m_pend;
        end
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cyc_valid",    {31'd0, Valid}, {31'd0, m_valid});
      chk("cyc_busy",     {31'd0, Busy},  {31'd0, m_busy});
      chk("cyc_quotient", Quotient,       m_q);
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    Number_1 = a;
    Number_2 = b;
    Start    = 1'b1;
    @(posedge clk); #1;
    Start    = 1'b0;
  endtask

  task automatic wait_valid(input logic [31:0] expq, input int explat, input string nm,
                            input int ign1, input int ign2, input int celo, input int celen);
    int lat = 0;
    bit got = 0;
    while (lat < 100 && !got) begin
      @(posedge clk); #1;
      lat++;
      ce = (celen == 0) || !(lat >= celo && lat < celo + celen);
      if (lat == ign1 || lat == ign2) begin
        Number_1 = 32'h3F80_0000;
        Number_2 = 32'h4040_0000;
        Start    = 1'b1;
      end else begin
        Start = 1'b0;
      end
      if (Valid) got = 1;
    end
    Start = 1'b0;
    ce    = 1'b1;
    chk({nm, "_seen"},    {31'd0, got}, 32'd1);
    chk({nm, "_latency"}, lat,          explat);
    chk({nm, "_quot"},    Quotient,     expq);
  endtask

  task automatic no_valid(input int n, input string nm);
    repeat (n) begin
      @(posedge clk); #1;
      chk(nm, {31'd0, Valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; Start = 1'b0; Number_1 = '0; Number_2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_quot",  Quotient,       32'd0);
    chk("reset_valid", {31'd0, Valid}, 32'd0);
    chk("reset_busy",  {31'd0, Busy},  32'd0);

    // Pin the reference model to hand-computed values
    chk("pin_6_3",   exp_div(32'h40C0_0000, 32'h4040_0000), 32'h4000_0000);
    chk("pin_1_3",   exp_div(32'h3F80_0000, 32'h4040_0000), 32'h3EAA_AAAA);
    chk("pin_m6_3",  exp_div(32'hC0C0_0000, 32'h4040_0000), 32'hC000_0000);
    chk("pin_x_0",   exp_div(32'h3F80_0000, 32'h0000_0000), 32'h7F80_0000);
    chk("pin_0_0",   exp_div(32'h0000_0000, 32'h0000_0000), 32'h7FC0_0000);
    chk("pin_ovf",   exp_div(32'h7F00_0000, 32'h0080_0000), 32'h7F80_0000);
    chk("pin_unf",   exp_div(32'h0080_0000, 32'h7F00_0000), 32'h0000_0000);

    @(posedge clk); #1;
    issue(32'h40C0_0000, 32'h4040_0000);
    chk("busy_after_accept", {31'd0, Busy}, 32'd1);
    wait_valid(32'h4000_0000, 26, "div_6_3", 0, 0, 0, 0);
    no_valid(1, "valid_one_pulse");

    issue(32'h3F80_0000, 32'h4040_0000); wait_valid(32'h3EAA_AAAA, 26, "div_1_3",   0, 0, 0, 0);
    issue(32'hC0C0_0000, 32'h4040_0000); wait_valid(32'hC000_0000, 26, "div_m6_3",  0, 0, 0, 0);
    issue(32'h3F80_0000, 32'h0000_0000); wait_valid(32'h7F80_0000, 26, "div_by_0",  0, 0, 0, 0);
    issue(32'h0000_0000, 32'h40A0_0000); wait_valid(32'h0000_0000, 26, "zero_div",  0, 0, 0, 0);
    issue(32'h0000_0000, 32'h0000_0000); wait_valid(32'h7FC0_0000, 26, "zero_zero", 0, 0, 0, 0);
    issue(32'h7F00_0000, 32'h0080_0000); wait_valid(32'h7F80_0000, 26, "overflow",  0, 0, 0, 0);
    issue(32'h0080_0000, 32'h7F00_0000); wait_valid(32'h0000_0000, 26, "underflow", 0, 0, 0, 0);

    // Starts while busy are ignored
    issue(32'h40C0_0000, 32'h4040_0000);
    wait_valid(32'h4000_0000, 26, "ignored_start", 5, 10, 0, 0);
    no_valid(30, "no_extra_valid");

    // Back-to-back: new Start in the Valid cycle
    issue(32'h40C0_0000, 32'h4040_0000);
    wait_valid(32'h4000_0000, 26, "b2b_first", 0, 0, 0, 0);
    issue(32'h3F80_0000, 32'h4040_0000);
    wait_valid(32'h3EAA_AAAA, 26, "b2b_second", 0, 0, 0, 0);

    // ce low for 7 cycles mid-divide, then ce low while Valid is high
    issue(32'hC0C0_0000, 32'h4040_0000);
    wait_valid(32'hC000_0000, 33, "ce_stall", 0, 0, 8, 7);
    ce = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("valid_held_ce_low", {31'd0, Valid}, 32'd1);
    end
    ce = 1'b1;
    @(posedge clk); #1;
    chk("valid_clear_ce_back", {31'd0, Valid}, 32'd0);

    // Reset mid-operation
    issue(32'h40C0_0000, 32'h4040_0000);
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy",  {31'd0, Busy},  32'd0);
    chk("abort_valid", {31'd0, Valid}, 32'd0);
    chk("abort_quot",  Quotient,       32'd0);
    no_valid(40, "abort_no_valid");
    issue(32'h40C0_0000, 32'h4040_0000);
    wait_valid(32'h4000_0000, 26, "after_abort", 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/float_division.md
# float_division

Sequential IEEE-754 single-precision divider, the inverse companion of the pipelined float multiplier in the inverse-square-root datapath. It computes Quotient = Number_1 / Number_2 with a restoring mantissa divider, one quotient bit per cycle, behind a start/busy/valid handshake. It is used to produce reference 1/sqrt(x) values and to check Newton-iteration outputs against a true division.

## Interface
- No parameters; the format is fixed at 32-bit single precision.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, all state and outputs hold.
- Start  in  1  request; sampled only in IDLE with ce=1.
- Number_1  in  32  dividend; latched on an accepted Start.
- Number_2  in  32  divisor; latched on an accepted Start.
- Quotient  out  32  result register; holds its value until the next result.
- Valid  out  1  one-cycle pulse when Quotient is updated.
- Busy  out  1  high from the accepting edge until the result edge.

## Operation
- States: IDLE, DIVIDE, NORM.
- Reset: state IDLE; Quotient=0, Valid=0, Busy=0; internal counter and registers cleared.
- IDLE with Start=1 and ce=1:
  - Latch the operands.
  - Set sign = N1[31] ^ N2[31].
  - Set rem = {1,N1[22:0]} (26 bits), div = {1,N2[22:0]}, q = 0, cnt = 0.
  - Set Busy=1 and go to DIVIDE.
- DIVIDE, one iteration per enabled edge:
  - If rem >= div: q = {q[23:0],1} and rem = (rem-div)<<1.
  - Otherwise: q = {q[23:0],0} and rem = rem<<1.
  - cnt increments. After the 25th iteration (cnt=24), go to NORM.
- NORM, one enabled edge. This edge writes Quotient, pulses Valid, clears Busy and returns to IDLE.
  - E = e1 - e2 + 127 - (q[24] ? 0 : 1), computed 10-bit signed.
  - Mantissa = q[24] ? q[23:1] : q[22:0]. It is truncated, not rounded, to match the multiplier.
- Result priority, first match wins:
  - e1=0 and e2=0 gives 0x7FC00000.
  - e2=0 gives {sign, 0xFF, 0}.
  - e1=0 gives {sign, 31'b0}.
  - E >= 255 gives {sign, 0xFF, 0}.
  - E <= 0 gives {sign, 31'b0}.
  - Otherwise {sign, E[7:0], mantissa}.
- Exponent field 0 means zero; denormals are flushed. Exponent 255 on an input gets no NaN/Inf handling and is processed arithmetically.
- Start while Busy=1 is ignored; the in-flight operation is unaffected.

## Timing
- Fixed latency of 26 enabled edges for all inputs, including special cases.
  - Edge 0 accepts Start.
  - Edges 1 to 25 are the DIVIDE iterations.
  - Edge 26 is NORM; Quotient and Valid are visible after it.
- Valid is high for exactly one enabled cycle and is cleared on the next ce=1 edge.
- If ce is low while Valid=1, Valid stays high until ce returns.
- ce low mid-operation stretches latency by the number of disabled cycles; the result is unchanged.
- Back-to-back: Start may be high in the cycle Valid is high. It is accepted on that edge because the state is IDLE, giving a throughput of one result per 27 cycles.
- rst mid-operation returns to IDLE next edge with Quotient=0, Valid=0, Busy=0. The aborted result is never produced.
- rst has priority over ce.

## Test plan
- 0x40C00000 / 0x40400000 (6/3): Busy for 26 cycles, then Quotient=0x40000000 with one Valid pulse.
- 0x3F800000 / 0x40400000 (1/3): Quotient=0x3EAAAAAA (truncated); also 0xC0C00000 / 0x40400000 gives 0xC0000000.
- Special cases, each at a 26-cycle latency:
  - 0x3F800000 / 0 gives 0x7F800000.
  - 0 / 0x40A00000 gives 0x00000000.
  - 0 / 0 gives 0x7FC00000.
  - 0x7F000000 / 0x00800000 gives 0x7F800000 (overflow).
  - 0x00800000 / 0x7F000000 gives 0x00000000 (underflow).
- Start pulsed at cycles 5 and 10 during a busy operation: both ignored, one Valid only. A Start in the Valid cycle is accepted, and the next result arrives 26 edges later.
- ce held low for 7 cycles mid-DIVIDE: Valid after 33 cycles, same Quotient. ce low during the Valid cycle keeps Valid high.
- rst asserted at iteration 12: next cycle Busy=0, Valid=0, Quotient=0, with no later Valid. A fresh 6/3 afterwards gives 0x40000000.
